channel_readout_arbiter: RTL

CHANNEL_READOUT_ARBITER -- requirements
Module: channel_readout_arbiter

---
 rtl/larpix_pkg.sv | 13 +
 rtl/rr_priority_encoder.sv | 30 +++
 rtl/channel_readout_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/larpix_pkg.sv
// Shared constants and types for the LArPix channel readout path.
package larpix_pkg;

    localparam int NUMCHANNELS_DEF = 64;
    localparam int CHAN_ID_W_DEF   = $clog2(NUMCHANNELS_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin pick: lowest eligible index strictly after last_grant,
// wrapping; last_grant itself only wins when it is the sole candidate.
module rr_priority_encoder
    import larpix_pkg::*;
#(
    parameter int NUMCHANNELS = NUMCHANNELS_DEF,
    parameter int CHAN_ID_W   = CHAN_ID_W_DEF
) (
    input  logic [NUMCHANNELS-1:0] eligible,
    input  logic [CHAN_ID_W-1:0]   last_grant,
    output logic [CHAN_ID_W-1:0]   winner,
    output logic                   any_valid
);

    logic [CHAN_ID_W-1:0] idx;

    always_comb begin
        winner    = last_grant;
        any_valid = |eligible;
        idx       = '0;
        // Walk from the farthest offset back so the nearest one wins.
        for (int k = NUMCHANNELS; k >= 1; k--) begin
            idx = CHAN_ID_W'((int'(last_grant) + k) % NUMCHANNELS);
            if (eligible[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/channel_readout_arbiter.sv
// Arbitrates per-channel FIFO heads into one shared FIFO,
// one word every two clocks, round-robin across channels.
module channel_readout_arbiter
    import larpix_pkg::*;
#(
    parameter int NUMCHANNELS = NUMCHANNELS_DEF,
    parameter int WORDW       = 58,
    parameter int CHAN_ID_W   = CHAN_ID_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUMCHANNELS-1:0]       req,
    input  logic [NUMCHANNELS*WORDW-1:0] chan_data,
    input  logic [NUMCHANNELS-1:0]       channel_mask,
    input  logic                         fifo_full,
    input  logic                         fifo_almost_full,
    output logic [NUMCHANNELS-1:0]       grant,
    output logic                         fifo_wr_en,
    output logic [CHAN_ID_W+WORDW-1:0]   fifo_data,
    output logic                         busy
);

    arb_state_t             state;
    logic [CHAN_ID_W-1:0]   last_grant;
    logic [CHAN_ID_W-1:0]   cap_id;
    logic [CHAN_ID_W-1:0]   winner;
    logic                   any_valid;
    logic [NUMCHANNELS-1:0] eligible;
    logic [NUMCHANNELS-1:0] win_onehot;
    logic                   idle_go;
    logic                   write_go;
    logic [WORDW-1:0]       words [NUMCHANNELS];

    for (genvar n = 0; n < NUMCHANNELS; n++) begin : g_words
        assign words[n] = chan_data[n*WORDW +: WORDW];
    end

    assign eligible   = req & ~channel_mask;
    assign win_onehot = {{(NUMCHANNELS-1){1'b0}}, 1'b1} << winner;
    assign idle_go    = any_valid & ~fifo_full;
    // Back-to-back needs room for the word after this one.
    assign write_go   = any_valid & ~fifo_full & ~fifo_almost_full;

    rr_priority_encoder #(
        .NUMCHANNELS (NUMCHANNELS),
        .CHAN_ID_W   (CHAN_ID_W)
    ) u_rr (
        .eligible   (eligible),
        .last_grant (last_grant),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            fifo_wr_en <= 1'b0;
            fifo_data  <= '0;
            busy       <= 1'b0;
            cap_id     <= '0;
            last_grant <= CHAN_ID_W'(NUMCHANNELS-1);
        end else begin
            unique case (state)
                IDLE: begin
                    fifo_wr_en <= 1'b0;
                    if (idle_go) begin
                        state  <= GRANT;
                        grant  <= win_onehot;
                        cap_id <= winner;
                        busy   <= 1'b1;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    // Head word is sampled before the pop takes effect.
                    state      <= WRITE;
                    grant      <= '0;
                    fifo_wr_en <= 1'b1;
                    fifo_data  <= {cap_id, words[cap_id]};
                    last_grant <= cap_id;
                    busy       <= 1'b1;
                end
                WRITE: begin
                    fifo_wr_en <= 1'b0;
                    if (write_go) begin
                        state  <= GRANT;
                        grant  <= win_onehot;
                        cap_id <= winner;
                        busy   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    grant      <= '0;
                    fifo_wr_en <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
